fetch_icache: RTL and testbench
===============================

Name: fetch_icache

Overview:
- Instruction fetcher directly downstream of the context manager's fetch port and upstream of instruction memory.
- Accepts one fetch request per cycle (fetch_order, fetch_pc) and answers from a direct-mapped instruction cache with zero-latency hit (fetch_done, fetch_instr in the same cycle).
- On a miss, runs a line-fill state machine against a request/ack memory port.
- The context manager holds fetch_order/fetch_pc until fetch_done unless a hazard redirects it. The block never latches the request; every answer is checked against the current fetch_pc.

Parameters:
- LINE_WORDS, 4, words per cache line; power of 2, >=2.
- SETS, 64, number of lines; power of 2.
- Derived: OFF=log2(LINE_WORDS), IDX=log2(SETS); byte PC; offset pc[OFF+1:2], index pc[OFF+1+IDX:OFF+2], tag pc[31:OFF+2+IDX]; pc[1:0] ignored.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- init  in  1  cpu init pulse; invalidates whole cache
- fetch_order  in  1  request valid this cycle
- fetch_pc  in  `LEN_WORD  requested byte PC
- fetch_done  out  1  fetch_instr valid for current fetch_pc (combinational)
- fetch_instr  out  `LEN_WORD  instruction word
- fetch_hint  in  `LEN_WORD  predicted future PC (used only with the optional feature)
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  `LEN_WORD  word-aligned byte address of the beat
- mem_ack  in  1  beat accepted; mem_rdata valid this cycle
- mem_rdata  in  `LEN_WORD  read data

Behaviour:
- Storage: valid[SETS] and tag[SETS] in flops; data[SETS*LINE_WORDS] in LUT RAM with async read.
- Hit: fetch_order & valid[idx] & tag[idx]==tag(fetch_pc) & !(state==FILL & idx==fill_idx).
  - fetch_done = hit, same cycle.
  - fetch_instr = data[idx][off] always, don't-care when !fetch_done.
- Miss: fetch_order & !hit & state==IDLE & !init.
  - Next edge: fill_tag/fill_idx latched, valid[fill_idx] cleared, beat counter cleared, state goes to FILL.
- FSM states:
  - IDLE: mem_req=0.
  - FILL:
    - mem_req=1, mem_addr={fill_tag, fill_idx, beat, 2'b00}.
    - On mem_ack, write mem_rdata to data[fill_idx][beat] and increment beat.
    - On ack of beat LINE_WORDS-1, go to COMMIT.
  - COMMIT: one cycle; valid[fill_idx]=1, tag[fill_idx]=fill_tag (unless discarded); go to IDLE. The re-presented request hits the cycle after COMMIT.
- Fill latency: misses in cycle t. With mem_ack every cycle, fetch_done rises at t+LINE_WORDS+2.
- Fill is never aborted by fetch_pc changes (hazard redirect). The line completes and is kept.
- Hit-under-miss: requests to other sets hit during FILL. A new miss during FILL waits; fetch_done stays 0 until the FSM returns to IDLE and the miss is taken.
- mem_req/mem_addr are registered. mem_addr is stable while mem_req=1 and !mem_ack. A new beat is presented the cycle after ack.
- init:
  - Clears all valid bits next edge.
  - fetch_done is forced 0 in the init cycle.
  - If asserted during FILL, a discard flag is set. The fill runs to completion (no dangling memory transaction), but COMMIT does not set valid.
- Simultaneous init and miss: init wins; no fill starts.
- Reset values: state IDLE, all valid 0, mem_req 0, mem_addr 0, beat 0, discard 0. Hence fetch_done=0 out of reset. Data RAM is not reset.
- Reset mid-fill: FSM returns to IDLE immediately. mem_req drops asynchronously, and the memory side must tolerate the dropped request.

Optional Feature:
- Macro FETCH_HINT_PREFETCH_EN.
- Defined:
  - In IDLE with no demand miss and no init, if the line of fetch_hint is not present (the same hit test without fetch_order), a fill of that line starts.
  - Demand misses have priority in the same cycle.
  - A prefetch fill is never preempted once started.
- Undefined: fetch_hint is ignored; fills occur only on demand miss.

Test Plan:
- After rst, fetch_order=1 with fetch_pc=0x0000_0000 -> fetch_done=0, mem_addr 0x0,0x4,0x8,0xC with ack each cycle -> fetch_done=1 at cycle t+6, fetch_instr=beat-0 data. Then pc=0x8 -> immediate hit with beat-2 data.
- Line 0 filled, request pc=0x0000_0400 (same index 0, tag 1) -> miss, refill replaces line 0. Subsequent pc=0x0 -> miss again (conflict).
- Fill of pc=0x100 in progress with mem_ack delayed 3 cycles/beat, request pc=0x0 (valid, other set) -> fetch_done=1 during FILL. Request pc=0x104 -> fetch_done=0 until after COMMIT.
- Fill of 0x200 in progress, fetch_pc switches to 0x0 (hazard) -> fill still completes all 4 beats. Later pc=0x200 hits with no memory traffic.
- init pulsed at beat 2 of a fill -> fill finishes 4 beats, no line valid afterwards. Previously valid pc=0x0 now misses.
- FETCH_HINT_PREFETCH_EN defined, idle, fetch_hint=0x0000_0800 absent -> fill of 0x800..0x80C issued. A later fetch_pc=0x804 hits immediately. Without the macro -> no memory traffic.

Source files
------------

// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache for the fetch path, with a line-fill FSM on a req/ack memory port.
// Latency: hit answers combinationally; a miss answers LINE_WORDS+2 cycles later with one ack per cycle.
// Backpressure: fetch_done stays low until the line is present; mem_req/mem_addr hold until mem_ack.
// Optional hint prefetch is enabled by defining FETCH_HINT_PREFETCH_EN.

`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module fetch_icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 fetch_order,
  input  logic [`LEN_WORD-1:0] fetch_pc,
  output logic                 fetch_done,
  output logic [`LEN_WORD-1:0] fetch_instr,
  input  logic [`LEN_WORD-1:0] fetch_hint,
  output logic                 mem_req,
  output logic [`LEN_WORD-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [`LEN_WORD-1:0] mem_rdata
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = `LEN_WORD - OFF - 2 - IDX;
  localparam logic [OFF-1:0] BEAT_LAST = OFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state;

  // Tag/valid live in flops; line data is a LUT RAM with asynchronous read.
  logic [SETS-1:0]      valid;
  logic [TAGW-1:0]      tag_mem  [SETS];
  logic [`LEN_WORD-1:0] data_mem [SETS*LINE_WORDS];

  logic [TAGW-1:0] fill_tag;
  logic [IDX-1:0]  fill_idx;
  logic [OFF-1:0]  beat;
  logic            discard;

  // Demand request fields; the request is never latched, always decoded live.
  logic [OFF-1:0]  pc_off;
  logic [IDX-1:0]  pc_idx;
  logic [TAGW-1:0] pc_tag;
  logic            pc_set_filling;
  logic            hit;
  logic            demand_miss;

  assign pc_off = fetch_pc[OFF+1:2];
  assign pc_idx = fetch_pc[OFF+1+IDX:OFF+2];
  assign pc_tag = fetch_pc[`LEN_WORD-1:OFF+2+IDX];

  // The set being refilled holds partially written data, so it must never hit.
  assign pc_set_filling = (state == ST_FILL) && (pc_idx == fill_idx);
  assign hit = fetch_order && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag) && !pc_set_filling;
  assign fetch_done  = hit && !init;
  assign fetch_instr = data_mem[{pc_idx, pc_off}];

  // init takes precedence over a miss in the same cycle: no fill is started.
  assign demand_miss = fetch_order && !hit && (state == ST_IDLE) && !init;

  // Prefetch candidate taken from the hint; only considered when no demand miss is pending.
  logic [IDX-1:0]  hint_idx;
  logic [TAGW-1:0] hint_tag;
  logic            pf_start;
  logic            unused_bits;

`ifdef FETCH_HINT_PREFETCH_EN
  logic hint_present;

  assign hint_idx     = fetch_hint[OFF+1+IDX:OFF+2];
  assign hint_tag     = fetch_hint[`LEN_WORD-1:OFF+2+IDX];
  assign hint_present = valid[hint_idx] && (tag_mem[hint_idx] == hint_tag);
  assign pf_start     = (state == ST_IDLE) && !demand_miss && !init && !hint_present;
  assign unused_bits  = ^{fetch_hint[OFF+1:0], fetch_pc[1:0]};
`else
  assign hint_idx    = '0;
  assign hint_tag    = '0;
  assign pf_start    = 1'b0;
  assign unused_bits = ^{fetch_hint, fetch_pc[1:0]};
`endif

  // Line selected for a fill started this cycle; demand always beats prefetch.
  logic            fill_start;
  logic [IDX-1:0]  start_idx;
  logic [TAGW-1:0] start_tag;

  assign fill_start = demand_miss || pf_start;
  assign start_idx  = demand_miss ? pc_idx : hint_idx;
  assign start_tag  = demand_miss ? pc_tag : hint_tag;

  // Fill FSM, registered memory port and valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      beat     <= '0;
      discard  <= 1'b0;
      fill_tag <= '0;
      fill_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            fill_tag <= start_tag;
            fill_idx <= start_idx;
            beat     <= '0;
            discard  <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= {start_tag, start_idx, {OFF{1'b0}}, 2'b00};
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          // A fill always runs to its last beat so memory never sees an abandoned request.
          if (init) begin
            discard <= 1'b1;
          end
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (beat == BEAT_LAST) begin
              mem_req <= 1'b0;
              state   <= ST_COMMIT;
            end else begin
              mem_addr <= {fill_tag, fill_idx, beat + 1'b1, 2'b00};
            end
          end
        end
        ST_COMMIT: begin
          discard <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase

      // init wipes everything, including a line that would commit this cycle.
      if (init) begin
        valid <= '0;
      end else if ((state == ST_IDLE) && fill_start) begin
        valid[start_idx] <= 1'b0;
      end else if ((state == ST_COMMIT) && !discard) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Line data and tag writes; the tag is only trusted once valid is set.
  always_ff @(posedge clk) begin
    if ((state == ST_FILL) && mem_ack) begin
      data_mem[{fill_idx, beat}] <= mem_rdata;
    end
    if (state == ST_COMMIT) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_fetch_icache.sv
// Bench for fetch_icache: directed scenarios then random traffic, all checked against a line-level cache model.
// Latency: one check point per clock, sampled on the falling edge.
// Backpressure: the bench acts as memory and acks beats at a chosen or random rate.

`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module tb_fetch_icache;

  localparam int LW         = 4;
  localparam int NS         = 64;
  localparam int LINE_BYTES = LW * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        fetch_order;
  logic [31:0] fetch_pc;
  logic        fetch_done;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_hint;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_icache #(.LINE_WORDS(LW), .SETS(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .fetch_order(fetch_order),
    .fetch_pc   (fetch_pc),
    .fetch_done (fetch_done),
    .fetch_instr(fetch_instr),
    .fetch_hint (fetch_hint),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Reference model: which memory line each set holds, plus the one line being fetched.
  bit          present [NS];
  int unsigned line_at [NS];
  bit          fill_on;
  int unsigned fill_line;
  int          fill_beats;
  bit          fill_discard;
  bit          last_done;
  bit          last_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5EED_C0DE;
  endfunction

  function automatic int unsigned line_of(input logic [31:0] pc);
    return pc / LINE_BYTES;
  endfunction

  function automatic int set_of(input int unsigned ln);
    return int'(ln % NS);
  endfunction

  function automatic bit line_cached(input int unsigned ln);
    return present[set_of(ln)] && (line_at[set_of(ln)] == ln);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_fill(input int unsigned ln);
    fill_on      = 1'b1;
    fill_line    = ln;
    fill_beats   = 0;
    fill_discard = 1'b0;
    present[set_of(ln)] = 1'b0;
  endtask

  // One clock: drive inputs, check outputs on the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit ord, input logic [31:0] pc, input bit ini, input bit ack_ok,
                       input logic [31:0] hint_pc);
    bit          fetching;
    bit          hit;
    bit          exp_done;
    int unsigned ln;
    logic [31:0] exp_addr;
    logic [31:0] word_pc;
    fetch_order = ord;
    fetch_pc    = pc;
    init        = ini;
    fetch_hint  = hint_pc;
    ln          = line_of(pc);
    fetching    = fill_on && (fill_beats < LW);
    hit         = ord && line_cached(ln) && !(fetching && set_of(ln) == set_of(fill_line));
    exp_done    = hit && !ini;
    exp_addr    = 32'(fill_line * LINE_BYTES + fill_beats * 4);
    mem_ack     = ack_ok && fetching;
    mem_rdata   = mem_word(exp_addr);
    word_pc     = pc & 32'hFFFF_FFFC;
    @(negedge clk);
    check("fetch_done", {31'd0, fetch_done}, {31'd0, exp_done});
    if (exp_done) check("fetch_instr", fetch_instr, mem_word(word_pc));
    check("mem_req", {31'd0, mem_req}, {31'd0, fetching});
    if (fetching) check("mem_addr", mem_addr, exp_addr);
    last_done = fetch_done;
    last_req  = mem_req;
    @(posedge clk);
    if (fetching) begin
      if (mem_ack) fill_beats++;
      if (ini) fill_discard = 1'b1;
    end else if (fill_on) begin
      if (!fill_discard && !ini) begin
        present[set_of(fill_line)] = 1'b1;
        line_at[set_of(fill_line)] = fill_line;
      end
      fill_on = 1'b0;
    end else if (ord && !hit && !ini) begin
      start_fill(ln);
    end
`ifdef FETCH_HINT_PREFETCH_EN
    else if (!ini && !line_cached(line_of(hint_pc))) begin
      start_fill(line_of(hint_pc));
    end
`endif
    if (ini) begin
      foreach (present[i]) present[i] = 1'b0;
    end
    #1;
  endtask

  // Hold a request until it is answered; n counts cycles including the answering one.
  task automatic fetch_until_done(input logic [31:0] pc, input int ack_div, output int n);
    n = 0;
    last_done = 1'b0;
    while (!last_done && n < 200) begin
      cycle(1'b1, pc, 1'b0, (n % ack_div) == 0, pc);
      n++;
    end
    if (!last_done) check("fetch_timeout", {31'd0, last_done}, 32'd1);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    logic [31:0] s;
    logic [31:0] o;
    t = $urandom_range(0, 2);
    s = $urandom_range(0, 3);
    o = $urandom_range(0, LW - 1);
    return (t << 10) | (s << 4) | (o << 2) | ($urandom & 32'h3);
  endfunction

  initial begin
    int          n;
    int          req_cycles;
    logic [31:0] pc;
    logic [31:0] hint_pc;

    rst = 1'b1; init = 1'b0; fetch_order = 1'b1; fetch_pc = '0;
    fetch_hint = '0; mem_ack = 1'b0; mem_rdata = '0;
    fill_on = 1'b0; fill_beats = 0; fill_discard = 1'b0; fill_line = 0;
    foreach (present[i]) present[i] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold miss on line 0 with an ack every cycle, then a hit on word 2.
    fetch_until_done(32'h0, 1, n);
    check("cold_miss_latency", n - 1, LW + 2);
    cycle(1'b1, 32'h8, 1'b0, 1'b1, 32'h8);
    check("hit_pc8", {31'd0, last_done}, 32'd1);

    // Same set, different tag: each evicts the other.
    fetch_until_done(32'h400, 1, n);
    check("conflict_latency_400", n - 1, LW + 2);
    fetch_until_done(32'h0, 1, n);
    check("conflict_latency_0", n - 1, LW + 2);

    // Hit-under-miss with slow memory, then a request into the set being filled.
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h100);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 32'h0, 1'b0, (k % 4) == 3, 32'h0);
      if (k == 0) check("hit_under_miss", {31'd0, last_done}, 32'd1);
    end
    fetch_until_done(32'h104, 4, n);

    // Redirect away mid-fill; the fill still lands.
    cycle(1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
    cycle(1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
    check("redirect_fill_kept", {31'd0, last_done}, 32'd1);
    check("redirect_no_traffic", {31'd0, last_req}, 32'd0);

    // init on beat 2: the fill completes but nothing is left valid.
    cycle(1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
    cycle(1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
    cycle(1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
    cycle(1'b1, 32'h300, 1'b1, 1'b1, 32'h300);
    fetch_until_done(32'h300, 1, n);
    check("init_discard_refetch", {31'd0, (n - 1) > (LW + 2)}, 32'd1);
    cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
    check("init_line0_miss", {31'd0, last_done}, 32'd0);
    fetch_until_done(32'h0, 1, n);

    // Hint of an absent line while idle.
    req_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h800);
      if (last_req) req_cycles++;
    end
    cycle(1'b1, 32'h804, 1'b0, 1'b1, 32'h804);
`ifdef FETCH_HINT_PREFETCH_EN
    check("prefetch_beats", req_cycles, LW);
    check("prefetch_hit", {31'd0, last_done}, 32'd1);
`else
    check("hint_no_traffic", req_cycles, 0);
    check("hint_ignored_miss", {31'd0, last_done}, 32'd0);
`endif
    fetch_until_done(32'h804, 1, n);

    // Random traffic: hazards, slow memory, occasional init.
    pc = rand_pc();
    for (int k = 0; k < 3000; k++) begin
      if (last_done || ($urandom_range(0, 3) == 0)) pc = rand_pc();
      hint_pc = rand_pc();
      cycle($urandom_range(0, 7) != 0, pc, $urandom_range(0, 63) == 0,
            $urandom_range(0, 1) == 1, hint_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
